// File: rtl/rvfi_trace_fifo.sv
// Trace buffer for the RVFI retirement port: captures retired-instruction records into a
// circular FIFO, drains them through a valid/ready handshake, and tracks drops and order gaps.
module rvfi_trace_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     rvfi_valid,
    input  logic [63:0]              rvfi_order,
    input  logic [31:0]              rvfi_insn,
    input  logic                     rvfi_trap,
    input  logic [31:0]              rvfi_pc_rdata,
    input  logic [31:0]              rvfi_pc_wdata,
    input  logic [4:0]               rvfi_rd_addr,
    input  logic [31:0]              rvfi_rd_wdata,
    input  logic [31:0]              rvfi_mem_addr,
    input  logic [3:0]               rvfi_mem_rmask,
    input  logic [3:0]               rvfi_mem_wmask,
    input  logic [31:0]              rvfi_mem_rdata,
    input  logic [31:0]              rvfi_mem_wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_order,
    output logic [31:0]              out_insn,
    output logic                     out_trap,
    output logic [31:0]              out_pc_rdata,
    output logic [31:0]              out_pc_wdata,
    output logic [4:0]               out_rd_addr,
    output logic [31:0]              out_rd_wdata,
    output logic [31:0]              out_mem_addr,
    output logic [3:0]               out_mem_rmask,
    output logic [3:0]               out_mem_wmask,
    output logic [31:0]              out_mem_rdata,
    output logic [31:0]              out_mem_wdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     order_error
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] insn;
        logic        trap;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rec_t;

    rec_t             mem_q [DEPTH];
    rec_t             in_rec;
    rec_t             head_q, head_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             order_err_q, order_err_d;
    logic [63:0]      exp_order_q, exp_order_d;
    logic             exp_valid_q, exp_valid_d;
    logic             full, push, pop;

    assign in_rec = '{
        order:     rvfi_order,
        insn:      rvfi_insn,
        trap:      rvfi_trap,
        pc_rdata:  rvfi_pc_rdata,
        pc_wdata:  rvfi_pc_wdata,
        rd_addr:   rvfi_rd_addr,
        rd_wdata:  rvfi_rd_wdata,
        mem_addr:  rvfi_mem_addr,
        mem_rmask: rvfi_mem_rmask,
        mem_wmask: rvfi_mem_wmask,
        mem_rdata: rvfi_mem_rdata,
        mem_wdata: rvfi_mem_wdata
    };

    assign full      = (level_q == LVL_W'(DEPTH));
    assign out_valid = (level_q != '0);
    assign pop       = out_valid && out_ready;
    assign push      = rvfi_valid && (!full || pop);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        drop_d      = drop_q;
        order_err_d = order_err_q;
        exp_order_d = exp_order_q;
        exp_valid_d = exp_valid_q;
        head_d      = head_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end

        if (rvfi_valid && !push) begin
            overflow_d = 1'b1;
            if (drop_q != '1) begin
                drop_d = drop_q + 1'b1;
            end
        end

        // Dropped records still participate in order checking.
        if (rvfi_valid) begin
            if (exp_valid_q && (rvfi_order != exp_order_q)) begin
                order_err_d = 1'b1;
            end
            exp_order_d = rvfi_order + 64'd1;
            exp_valid_d = 1'b1;
        end

        // Head register tracks the next head entry; the incoming record is forwarded
        // when it lands exactly at the new head slot, so the array is not read mid-write.
        if (level_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                head_d = in_rec;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            drop_q      <= '0;
            order_err_q <= 1'b0;
            exp_order_q <= '0;
            exp_valid_q <= 1'b0;
            head_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            drop_q      <= drop_d;
            order_err_q <= order_err_d;
            exp_order_q <= exp_order_d;
            exp_valid_q <= exp_valid_d;
            head_q      <= head_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= in_rec;
        end
    end

    assign out_order     = head_q.order;
    assign out_insn      = head_q.insn;
    assign out_trap      = head_q.trap;
    assign out_pc_rdata  = head_q.pc_rdata;
    assign out_pc_wdata  = head_q.pc_wdata;
    assign out_rd_addr   = head_q.rd_addr;
    assign out_rd_wdata  = head_q.rd_wdata;
    assign out_mem_addr  = head_q.mem_addr;
    assign out_mem_rmask = head_q.mem_rmask;
    assign out_mem_wmask = head_q.mem_wmask;
    assign out_mem_rdata = head_q.mem_rdata;
    assign out_mem_wdata = head_q.mem_wdata;

    assign level       = level_q;
    assign overflow    = overflow_q;
    assign drop_count  = drop_q;
    assign order_error = order_err_q;

endmodule

// File: tb/tb_rvfi_trace_fifo.sv
// Self-checking bench for rvfi_trace_fifo: a queue scoreboard with a negedge monitor,
// plus per-scenario tasks with targeted checks.
module tb_rvfi_trace_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] insn;
        logic        trap;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rec_t;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic                   rvfi_valid = 1'b0;
    logic                   out_ready = 1'b0;
    rec_t                   drv = '0;
    rec_t                   got;
    logic                   out_valid;
    logic [63:0]            out_order;
    logic [31:0]            out_insn;
    logic                   out_trap;
    logic [31:0]            out_pc_rdata, out_pc_wdata, out_rd_wdata, out_mem_addr;
    logic [31:0]            out_mem_rdata, out_mem_wdata;
    logic [4:0]             out_rd_addr;
    logic [3:0]             out_mem_rmask, out_mem_wmask;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow;
    logic [CNT_W-1:0]       drop_count;
    logic                   order_error;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    rec_t             sbq[$];
    rec_t             m_last = '0;
    logic             m_ovf = 1'b0, m_oerr = 1'b0, m_expv = 1'b0;
    logic [CNT_W-1:0] m_drop = '0;
    logic [63:0]      m_exp = '0;
    logic [63:0]      last_pop = '0;

    rvfi_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .rvfi_valid(rvfi_valid),
        .rvfi_order(drv.order), .rvfi_insn(drv.insn), .rvfi_trap(drv.trap),
        .rvfi_pc_rdata(drv.pc_rdata), .rvfi_pc_wdata(drv.pc_wdata),
        .rvfi_rd_addr(drv.rd_addr), .rvfi_rd_wdata(drv.rd_wdata),
        .rvfi_mem_addr(drv.mem_addr), .rvfi_mem_rmask(drv.mem_rmask),
        .rvfi_mem_wmask(drv.mem_wmask), .rvfi_mem_rdata(drv.mem_rdata),
        .rvfi_mem_wdata(drv.mem_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_order(out_order), .out_insn(out_insn), .out_trap(out_trap),
        .out_pc_rdata(out_pc_rdata), .out_pc_wdata(out_pc_wdata),
        .out_rd_addr(out_rd_addr), .out_rd_wdata(out_rd_wdata),
        .out_mem_addr(out_mem_addr), .out_mem_rmask(out_mem_rmask),
        .out_mem_wmask(out_mem_wmask), .out_mem_rdata(out_mem_rdata),
        .out_mem_wdata(out_mem_wdata),
        .level(level), .overflow(overflow), .drop_count(drop_count),
        .order_error(order_error)
    );

    assign got = {out_order, out_insn, out_trap, out_pc_rdata, out_pc_wdata, out_rd_addr,
                  out_rd_wdata, out_mem_addr, out_mem_rmask, out_mem_wmask,
                  out_mem_rdata, out_mem_wdata};

    always #5 clock = ~clock;

    // Reference model: queue-based FIFO, updated on each rising edge.
    always @(posedge clock) begin
        bit mpop, mpush;
        if (reset) begin
            sbq.delete();
            m_ovf = 1'b0; m_oerr = 1'b0; m_expv = 1'b0; m_drop = '0; m_last = '0;
        end else begin
            mpop  = (sbq.size() > 0) && out_ready;
            mpush = rvfi_valid && ((sbq.size() < DEPTH) || mpop);
            if (rvfi_valid) begin
                if (m_expv && (drv.order != m_exp)) m_oerr = 1'b1;
                m_exp  = drv.order + 64'd1;
                m_expv = 1'b1;
            end
            if (rvfi_valid && !mpush) begin
                m_ovf = 1'b1;
                if (m_drop != '1) m_drop = m_drop + 1'b1;
            end
            if (mpop) begin
                m_last   = sbq.pop_front();
                last_pop = m_last.order;
            end
            if (mpush) sbq.push_back(drv);
        end
    end

    // Monitor: compares every registered output against the model mid-cycle.
    always @(negedge clock) begin
        if (mon_en) begin
            n_checks++;
            if (out_valid !== (sbq.size() > 0)) begin
                n_fail++; $display("FAIL mon_valid: got %b expected %b", out_valid, sbq.size() > 0);
            end
            n_checks++;
            if (level !== ($clog2(DEPTH)+1)'(sbq.size())) begin
                n_fail++; $display("FAIL mon_level: got %0d expected %0d", level, sbq.size());
            end
            n_checks++;
            if ({overflow, drop_count, order_error} !== {m_ovf, m_drop, m_oerr}) begin
                n_fail++;
                $display("FAIL mon_status: got ovf=%b drop=%0d oerr=%b expected ovf=%b drop=%0d oerr=%b",
                         overflow, drop_count, order_error, m_ovf, m_drop, m_oerr);
            end
            n_checks++;
            if (sbq.size() > 0) begin
                if (got !== sbq[0]) begin
                    n_fail++;
                    $display("FAIL mon_head: got order=%0d insn=%h expected order=%0d insn=%h",
                             out_order, out_insn, sbq[0].order, sbq[0].insn);
                end
            end else if (got !== m_last) begin
                n_fail++;
                $display("FAIL mon_hold: got order=%0d insn=%h expected order=%0d insn=%h",
                         out_order, out_insn, m_last.order, m_last.insn);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic put(input logic v, input logic [63:0] ord, input logic [31:0] insn);
        rvfi_valid     = v;
        drv.order      = ord;
        drv.insn       = insn;
        drv.trap       = 1'($urandom_range(0, 1));
        drv.pc_rdata   = $urandom;
        drv.pc_wdata   = $urandom;
        drv.rd_addr    = 5'($urandom_range(0, 31));
        drv.rd_wdata   = $urandom;
        drv.mem_addr   = $urandom;
        drv.mem_rmask  = 4'($urandom_range(0, 15));
        drv.mem_wmask  = 4'($urandom_range(0, 15));
        drv.mem_rdata  = $urandom;
        drv.mem_wdata  = $urandom;
    endtask

    task automatic do_reset();
        put(1'b0, 64'd0, 32'd0);
        out_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({out_valid, level, overflow, drop_count, order_error} !== '0) begin
            n_fail++;
            $display("FAIL reset_status: got valid=%b level=%0d ovf=%b drop=%0d oerr=%b expected all 0",
                     out_valid, level, overflow, drop_count, order_error);
        end
        n_checks++;
        if (got !== '0) begin
            n_fail++; $display("FAIL reset_fields: got order=%0d insn=%h expected 0", out_order, out_insn);
        end
        reset = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        put(1'b1, 64'd0, 32'h00500093);
        tick();
        put(1'b0, 64'd0, 32'd0);
        n_checks++;
        if (out_valid !== 1'b1 || out_insn !== 32'h00500093 || level !== 4'd1) begin
            n_fail++;
            $display("FAIL single_c1: got valid=%b insn=%h level=%0d expected 1 00500093 1",
                     out_valid, out_insn, level);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || level !== 4'd0) begin
            n_fail++; $display("FAIL single_c2: got valid=%b level=%0d expected 0 0", out_valid, level);
        end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            put(1'b1, 64'(i), $urandom);
            tick();
        end
        put(1'b0, 64'd0, 32'd0);
        n_checks++;
        if (level !== 4'd8 || overflow !== 1'b1 || drop_count !== 4'd2 || order_error !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_status: got level=%0d ovf=%b drop=%0d oerr=%b expected 8 1 2 0",
                     level, overflow, drop_count, order_error);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_order !== 64'(i)) begin
                n_fail++;
                $display("FAIL fill_drain: got valid=%b order=%0d expected 1 %0d", out_valid, out_order, i);
            end
            tick();
        end
        n_checks++;
        if (out_valid !== 1'b0 || level !== 4'd0) begin
            n_fail++; $display("FAIL fill_empty: got valid=%b level=%0d expected 0 0", out_valid, level);
        end
    endtask

    task automatic test_passthrough_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            put(1'b1, 64'(i), $urandom);
            tick();
        end
        out_ready = 1'b1;
        put(1'b1, 64'd8, 32'h12345678);
        tick();
        put(1'b0, 64'd0, 32'd0);
        out_ready = 1'b0;
        n_checks++;
        if (level !== 4'd8 || drop_count !== 4'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ptf_status: got level=%0d drop=%0d ovf=%b expected 8 0 0",
                     level, drop_count, overflow);
        end
        out_ready = 1'b1;
        repeat (8) tick();
        n_checks++;
        if (last_pop !== 64'd8 || level !== 4'd0) begin
            n_fail++; $display("FAIL ptf_tail: got last=%0d level=%0d expected 8 0", last_pop, level);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            put(1'b1, 64'(100 + i), $urandom);
            tick();
            n_checks++;
            if (level !== 4'd1 || out_order !== 64'(100 + i)) begin
                n_fail++;
                $display("FAIL b2b_stream: got level=%0d order=%0d expected 1 %0d", level, out_order, 100 + i);
            end
        end
        put(1'b0, 64'd0, 32'd0);
        tick();
        n_checks++;
        if (level !== 4'd0 || order_error !== 1'b0) begin
            n_fail++; $display("FAIL b2b_end: got level=%0d oerr=%b expected 0 0", level, order_error);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            put(1'b1, 64'(40 + i), $urandom);
            tick();
        end
        put(1'b0, 64'd0, 32'd0);
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_order !== 64'd40 || got !== sbq[0]) begin
                n_fail++;
                $display("FAIL bp_hold: got valid=%b order=%0d expected 1 40", out_valid, out_order);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        tick();
        n_checks++;
        if (level !== 4'd1 || out_order !== 64'd42) begin
            n_fail++; $display("FAIL bp_release2: got level=%0d order=%0d expected 1 42", level, out_order);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || level !== 4'd0) begin
            n_fail++; $display("FAIL bp_release3: got valid=%b level=%0d expected 0 0", out_valid, level);
        end
    endtask

    task automatic test_order_gap();
        do_reset();
        out_ready = 1'b1;
        put(1'b1, 64'd5, $urandom);
        tick();
        put(1'b1, 64'd6, $urandom);
        tick();
        n_checks++;
        if (order_error !== 1'b0) begin
            n_fail++; $display("FAIL gap_before: got oerr=%b expected 0", order_error);
        end
        put(1'b1, 64'd8, $urandom);
        tick();
        n_checks++;
        if (order_error !== 1'b1) begin
            n_fail++; $display("FAIL gap_detect: got oerr=%b expected 1", order_error);
        end
        put(1'b1, 64'd9, $urandom);
        tick();
        put(1'b1, 64'd10, $urandom);
        tick();
        put(1'b0, 64'd0, 32'd0);
        n_checks++;
        if (order_error !== 1'b1) begin
            n_fail++; $display("FAIL gap_sticky: got oerr=%b expected 1", order_error);
        end
        tick();
    endtask

    task automatic test_drop_saturate();
        do_reset();
        for (int i = 0; i < DEPTH + 20; i++) begin
            put(1'b1, 64'(i), $urandom);
            tick();
        end
        put(1'b0, 64'd0, 32'd0);
        n_checks++;
        if (drop_count !== 4'hF || overflow !== 1'b1 || level !== 4'd8) begin
            n_fail++;
            $display("FAIL sat_drop: got drop=%0d ovf=%b level=%0d expected 15 1 8",
                     drop_count, overflow, level);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            put(1'b1, 64'(i), $urandom);
            tick();
        end
        put(1'b0, 64'd0, 32'd0);
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        n_checks++;
        if (level !== 4'd4 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL mr_pre: got level=%0d ovf=%b expected 4 1", level, overflow);
        end
        reset = 1'b1;
        put(1'b1, 64'd77, $urandom);
        tick();
        reset = 1'b0;
        put(1'b0, 64'd0, 32'd0);
        n_checks++;
        if ({out_valid, level, overflow, drop_count} !== '0 || got !== '0) begin
            n_fail++;
            $display("FAIL mr_post: got valid=%b level=%0d ovf=%b drop=%0d order=%0d expected all 0",
                     out_valid, level, overflow, drop_count, out_order);
        end
        put(1'b1, 64'd1234, $urandom);
        tick();
        put(1'b1, 64'd1235, $urandom);
        tick();
        put(1'b0, 64'd0, 32'd0);
        n_checks++;
        if (order_error !== 1'b0 || level !== 4'd2 || out_order !== 64'd1234) begin
            n_fail++;
            $display("FAIL mr_first: got oerr=%b level=%0d order=%0d expected 0 2 1234",
                     order_error, level, out_order);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        test_reset();
        test_single();
        test_fill_overflow();
        test_passthrough_full();
        test_back_to_back();
        test_backpressure();
        test_order_gap();
        test_drop_saturate();
        test_mid_reset();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rvfi_trace_fifo.md
# rvfi_trace_fifo

Downstream trace buffer for the 2-stage core's RVFI retirement port. It captures every retired-instruction record (`rvfi_valid` pulse) into a fixed-depth FIFO and drains records to the contract/trace sink through a valid/ready handshake, so the sink may back-pressure without stalling the core. It also tracks `rvfi_order` continuity and counts records dropped on overflow, for the contract checker.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `CNT_W`, 16: width of the drop counter.

- `clock` in 1: sole clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `rvfi_valid` in 1: retirement strobe from core; one record per asserted cycle.
- `rvfi_order` in 64: retirement sequence number.
- `rvfi_insn` in 32: instruction word.
- `rvfi_trap` in 1: trap flag.
- `rvfi_pc_rdata` in 32: PC of the retired instruction.
- `rvfi_pc_wdata` in 32: next PC.
- `rvfi_rd_addr` in 5: destination register.
- `rvfi_rd_wdata` in 32: destination write data.
- `rvfi_mem_addr` in 32: memory address.
- `rvfi_mem_rmask` in 4: read byte mask.
- `rvfi_mem_wmask` in 4: write byte mask.
- `rvfi_mem_rdata` in 32: load data.
- `rvfi_mem_wdata` in 32: store data.
- `out_valid` out 1: head record is presented.
- `out_ready` in 1: sink accepts the head record.
- `out_order`, `out_insn`, `out_trap`, `out_pc_rdata`, `out_pc_wdata`, `out_rd_addr`, `out_rd_wdata`, `out_mem_addr`, `out_mem_rmask`, `out_mem_wmask`, `out_mem_rdata`, `out_mem_wdata` out (same widths as inputs): head record fields.
- `level` out $clog2(DEPTH)+1: current occupancy.
- `overflow` out 1: sticky; set when any record has been dropped.
- `drop_count` out CNT_W: number of dropped records; saturates at all-ones.
- `order_error` out 1: sticky; set on an `rvfi_order` discontinuity.

## Operation
- Storage: DEPTH-entry circular buffer. Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The occupancy counter is a separate `level` register.
- Push: occurs when `rvfi_valid` is high and (`level` < DEPTH, or a pop happens in the same cycle). The record is written at the write pointer, and the write pointer advances.
- Pop: occurs when `out_valid` and `out_ready` are both high. The read pointer advances.
- Level update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
- Full with pop in the same cycle: the push is accepted (pass-through-full). Full without pop: the record is dropped, `overflow` is set to 1, and `drop_count` is incremented (saturating).
- Empty: `out_valid` = 0 and the out_* fields hold their last value. Records do not bypass the buffer: a record pushed into an empty FIFO becomes visible the next cycle.
- Order tracking:
  - `exp_order` (64 bits) is invalid after reset.
  - On each `rvfi_valid`, including dropped records: if `exp_order` is valid and `rvfi_order` ≠ `exp_order`, set `order_error`.
  - Then, in every case, load `exp_order` ← `rvfi_order` + 1 and mark it valid.
  - The addition wraps modulo 2^64.
- `overflow` and `order_error` clear only on reset.

## Timing
- Reset values:
  - `out_valid`=0, `level`=0, `overflow`=0, `drop_count`=0, `order_error`=0.
  - All out_* data fields = 0.
  - Pointers = 0; `exp_order` invalid.
- Latency: a record pushed in cycle N appears on `out_valid`/out_* in cycle N+1 at the earliest.
- Throughput: one push and one pop per cycle, sustained.
- out_* fields come from the head entry register; they are stable while `out_valid`=1 and `out_ready`=0.
- `level`, `overflow`, `drop_count` and `order_error` are registered and reflect events of the previous cycle.
- Reset asserted mid-operation: all contents are discarded and every output returns to its reset value on the next edge. `rvfi_valid` is ignored while `reset` is high.

## Test plan
- Single record: after reset, push order=0, insn=0x00500093 with `out_ready`=1.
  - Required: cycle+1 shows `out_valid`=1, `out_insn`=0x00500093, `level`=1.
  - Required: cycle+2 shows `out_valid`=0, `level`=0.
- Fill and overflow: DEPTH=8, `out_ready`=0, push orders 0..9 on consecutive cycles.
  - Required: `level`=8, `overflow`=1, `drop_count`=2, `order_error`=0.
  - Required: draining yields orders 0..7 in sequence.
- Pass-through-full: with the FIFO full, assert `out_ready`=1 and push order=8 in the same cycle.
  - Required: no drop, `level` stays 8, `drop_count` unchanged.
  - Required: the tail record drained last is order 8.
- Back-pressure stability: while 3 records are queued, hold `out_ready`=0 for 5 cycles.
  - Required: out_* fields stay constant and `out_valid` stays 1.
  - Required: after release, 3 pops in 3 cycles.
- Order gap: push orders 5, 6, 8.
  - Required: `order_error`=0 after the 6, and =1 the cycle after the 8.
  - Required: it remains 1 through further in-order pushes 9, 10.
- Mid-operation reset: with 4 queued and `overflow`=1, pulse `reset` for one cycle.
  - Required: `out_valid`=0, `level`=0, `overflow`=0, `drop_count`=0.
  - Required: a new first record with any order value does not set `order_error`.
